// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display with frame-aligned value commit.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seven_seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  load_i,
    output logic                  load_ready_o,
    output logic [3:0]            code_led_o,
    output logic [DIGITS-1:0]     digit_en_o,
    output logic                  blank_o,
    output logic                  frame_o
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] P_LAST    = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_PRE     = PW'(CLK_DIV - 2);
    localparam logic [PW-1:0] P_BL_LAST = PW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] I_LAST    = IW'(DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                r_state, w_state_nxt;
    logic [PW-1:0]         r_presc, w_presc_nxt;
    logic [IW-1:0]         r_idx, w_idx_nxt;
    logic [4*DIGITS-1:0]   r_disp, r_pend, w_disp_nxt;
    logic                  r_pend_v;
    logic [3:0]            r_code, w_code_nxt;
    logic [DIGITS-1:0]     r_en, w_en_nxt;
    logic                  r_blank, r_frame, w_frame_nxt;
    logic                  w_wrap, w_commit, w_lz, w_lit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_BLANK;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc + 1'b1;
        w_idx_nxt   = r_idx;
        w_wrap      = (r_presc == P_LAST);
        w_commit    = 1'b0;
        w_code_nxt  = 4'h0;
        w_lz        = 1'b0;
        w_lit       = 1'b0;
        w_en_nxt    = '1;
        w_frame_nxt = (r_presc == P_PRE) && (r_idx == I_LAST);

        if (w_wrap) begin
            w_presc_nxt = '0;
            w_idx_nxt   = (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
            w_commit    = (r_idx == I_LAST) && r_pend_v;
        end
        w_disp_nxt = w_commit ? r_pend : r_disp;

        case (r_state)
            ST_BLANK: if (r_presc == P_BL_LAST) w_state_nxt = ST_SHOW;
            ST_SHOW:  if (w_wrap)               w_state_nxt = ST_BLANK;
            default:                            w_state_nxt = ST_BLANK;
        endcase

        // Outputs are computed from next-cycle index/value so the new nibble appears with the slot.
        for (int k = 0; k < DIGITS; k++) begin
            if (w_idx_nxt == IW'(k)) w_code_nxt = w_disp_nxt[4*k +: 4];
        end

`ifdef SEG_SCAN_LZB_EN
        if (w_idx_nxt != '0) begin
            w_lz = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                if ((IW'(k) >= w_idx_nxt) && (w_disp_nxt[4*k +: 4] != 4'h0)) w_lz = 1'b0;
            end
        end
`else
        w_lz = 1'b0;
`endif

        w_lit = (w_state_nxt == ST_SHOW) && !w_lz;
        for (int k = 0; k < DIGITS; k++) begin
            w_en_nxt[k] = !(w_lit && (w_idx_nxt == IW'(k)));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_disp   <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_code   <= 4'h0;
            r_en     <= '1;
            r_blank  <= 1'b1;
            r_frame  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
            r_disp  <= w_disp_nxt;
            r_code  <= w_code_nxt;
            r_en    <= w_en_nxt;
            r_blank <= !w_lit;
            r_frame <= w_frame_nxt;
            // Commit and accept are exclusive: commit needs pend_v, accept needs !pend_v.
            if (load_i && !r_pend_v) begin
                r_pend   <= value_i;
                r_pend_v <= 1'b1;
            end else if (w_commit) begin
                r_pend_v <= 1'b0;
            end
        end
    end

    assign load_ready_o = ~r_pend_v;
    assign code_led_o   = r_code;
    assign digit_en_o   = r_en;
    assign blank_o      = r_blank;
    assign frame_o      = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus queues hand-computed expectations, a monitor checks them.
module tb_seven_seg_scan_ctrl;

`ifdef SEG_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic [15:0] value_i = 16'h0;
    logic        load_i = 1'b0;
    logic        load_ready_o;
    logic [3:0]  code_led_o;
    logic [3:0]  digit_en_o;
    logic        blank_o;
    logic        frame_o;

    seven_seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .value_i(value_i), .load_i(load_i),
        .load_ready_o(load_ready_o), .code_led_o(code_led_o), .digit_en_o(digit_en_o),
        .blank_o(blank_o), .frame_o(frame_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic       blank;
        logic [3:0] code;
        logic       frame;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_vec = 0;
    int   n_err = 0;
    bit   in_rst = 1'b0;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // cyc == -1 marks a check taken 1 time unit after reset assertion.
    always begin
        exp_t e;
        @(negedge clk_i or negedge rst_n_i);
        if (!rst_n_i) begin
            if (!in_rst) begin
                in_rst = 1'b1;
                #1;
                while (q.size() > 0 && q[0].cyc != -1) begin
                    e = q.pop_front();
                    n_vec++; n_err++;
                    $display("FAIL missed vec@%0d before reset", e.cyc);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    n_vec++;
                    if ({digit_en_o, blank_o, code_led_o, frame_o, load_ready_o} !==
                        {e.en, e.blank, e.code, e.frame, e.rdy}) begin
                        n_err++;
                        $display("FAIL reset: got en=%b blank=%b code=%h frame=%b rdy=%b, want en=%b blank=%b code=%h frame=%b rdy=%b",
                                 digit_en_o, blank_o, code_led_o, frame_o, load_ready_o,
                                 e.en, e.blank, e.code, e.frame, e.rdy);
                    end
                end
            end
        end else begin
            in_rst = 1'b0;
            while (q.size() > 0 && q[0].cyc != -1 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (e.cyc < cyc) begin
                    n_err++;
                    $display("FAIL missed vec@%0d (now cycle %0d)", e.cyc, cyc);
                end else if ({digit_en_o, blank_o, code_led_o, frame_o, load_ready_o} !==
                             {e.en, e.blank, e.code, e.frame, e.rdy}) begin
                    n_err++;
                    $display("FAIL vec@%0d: got en=%b blank=%b code=%h frame=%b rdy=%b, want en=%b blank=%b code=%h frame=%b rdy=%b",
                             e.cyc, digit_en_o, blank_o, code_led_o, frame_o, load_ready_o,
                             e.en, e.blank, e.code, e.frame, e.rdy);
                end
            end
        end
    end

    task automatic push(int c, logic [3:0] en, logic b, logic [3:0] code, logic fr, logic rdy);
        exp_t e;
        e.cyc = c; e.en = en; e.blank = b; e.code = code; e.frame = fr; e.rdy = rdy;
        q.push_back(e);
    endtask

    task automatic exp_blank(int c, logic [3:0] code, logic fr, logic rdy);
        push(c, 4'b1111, 1'b1, code, fr, rdy);
    endtask

    // lz: this slot's digit is a leading zero of the displayed value (hand-determined).
    task automatic exp_show(int c, logic [3:0] en, logic [3:0] code, logic fr, logic rdy, bit lz);
        if (LZB && lz) push(c, 4'b1111, 1'b1, code, fr, rdy);
        else           push(c, en, 1'b0, code, fr, rdy);
    endtask

    task automatic wait_cyc(int n);
        int k = 0;
        while (cyc != n) begin
            @(negedge clk_i);
            k++;
            if (k > 1000) begin
                $display("FAIL timeout waiting for cycle %0d", n);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic assert_reset();
        push(-1, 4'b1111, 1'b1, 4'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        load_i = 1'b0;
        repeat (2) @(posedge clk_i);
    endtask

    task automatic release_reset();
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
    endtask

    task automatic drive_load(int c, logic [15:0] v);
        wait_cyc(c);
        value_i = v;
        load_i  = 1'b1;
        wait_cyc(c + 1);
        load_i  = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0) begin
            @(negedge clk_i);
            k++;
            if (k > 500) begin
                $display("FAIL scoreboard not drained, %0d left", q.size());
                $fatal(1, "timeout");
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release, load 1A3F at 5, ignored load at 12.
        assert_reset();
        exp_blank(0, 4'h0, 0, 1);
        exp_blank(1, 4'h0, 0, 1);
        exp_show (2, 4'b1110, 4'h0, 0, 1, 0);
        exp_show (5, 4'b1110, 4'h0, 0, 1, 0);
        exp_show (6, 4'b1110, 4'h0, 0, 0, 0);
        exp_blank(8, 4'h0, 0, 0);
        exp_show (10, 4'b1101, 4'h0, 0, 0, 1);
        exp_show (13, 4'b1101, 4'h0, 0, 0, 1);
        exp_show (15, 4'b1101, 4'h0, 0, 0, 1);
        exp_blank(24, 4'h0, 0, 0);
        exp_show (26, 4'b0111, 4'h0, 0, 0, 1);
        exp_show (31, 4'b0111, 4'h0, 1, 0, 1);
        exp_blank(32, 4'hF, 0, 1);
        exp_show (34, 4'b1110, 4'hF, 0, 1, 0);
        exp_blank(40, 4'h3, 0, 1);
        exp_show (42, 4'b1101, 4'h3, 0, 1, 0);
        exp_blank(48, 4'hA, 0, 1);
        exp_show (50, 4'b1011, 4'hA, 0, 1, 0);
        exp_blank(56, 4'h1, 0, 1);
        exp_show (58, 4'b0111, 4'h1, 0, 1, 0);
        exp_show (63, 4'b0111, 4'h1, 1, 1, 0);
        exp_blank(64, 4'hF, 0, 1);
        release_reset();
        drive_load(5, 16'h1A3F);
        drive_load(12, 16'h2222);
        drain();

        // Load exactly on the frame-boundary cycle.
        assert_reset();
        exp_show (31, 4'b0111, 4'h0, 1, 1, 1);
        exp_blank(32, 4'h0, 0, 0);
        exp_show (34, 4'b1110, 4'h0, 0, 0, 0);
        exp_show (63, 4'b0111, 4'h0, 1, 0, 1);
        exp_blank(64, 4'h1, 0, 1);
        exp_show (66, 4'b1110, 4'h1, 0, 1, 0);
        exp_blank(72, 4'h2, 0, 1);
        exp_blank(80, 4'h3, 0, 1);
        exp_blank(88, 4'h4, 0, 1);
        exp_show (90, 4'b0111, 4'h4, 0, 1, 0);
        release_reset();
        drive_load(31, 16'h4321);
        drain();

        // Reset mid-slot with a value pending.
        assert_reset();
        exp_blank(0, 4'h0, 0, 1);
        exp_show (2, 4'b1110, 4'h0, 0, 1, 0);
        exp_show (4, 4'b1110, 4'h0, 0, 0, 0);
        exp_blank(8, 4'h0, 0, 0);
        exp_show (10, 4'b1101, 4'h0, 0, 0, 1);
        exp_show (12, 4'b1101, 4'h0, 0, 0, 1);
        release_reset();
        drive_load(3, 16'h1A3F);
        push(-1, 4'b1111, 1'b1, 4'h0, 1'b0, 1'b1);
        wait_cyc(12);
        #2 rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        exp_blank(0, 4'h0, 0, 1);
        exp_show (2, 4'b1110, 4'h0, 0, 1, 0);
        exp_show (31, 4'b0111, 4'h0, 1, 1, 1);
        exp_blank(32, 4'h0, 0, 1);
        exp_show (34, 4'b1110, 4'h0, 0, 1, 0);
        release_reset();
        drain();

        // Value 0050: digits 3 and 2 are leading zeros.
        assert_reset();
        exp_show (31, 4'b0111, 4'h0, 1, 0, 1);
        exp_blank(32, 4'h0, 0, 1);
        exp_show (34, 4'b1110, 4'h0, 0, 1, 0);
        exp_blank(40, 4'h5, 0, 1);
        exp_show (42, 4'b1101, 4'h5, 0, 1, 0);
        exp_show (50, 4'b1011, 4'h0, 0, 1, 1);
        exp_show (55, 4'b1011, 4'h0, 0, 1, 1);
        exp_show (58, 4'b0111, 4'h0, 0, 1, 1);
        exp_show (63, 4'b0111, 4'h0, 1, 1, 1);
        release_reset();
        drive_load(1, 16'h0050);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- Holds a DIGITS-nibble display value and presents one nibble per scan slot on code_led_o to the shared registered hex decoder (one-cycle latency, active-low segments).
- Drives active-low digit enables, with a blanking gap between digits to suppress ghosting.
- New values are accepted through a valid/ready handshake and committed only at frame boundaries, so the display never tears.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
CLK_DIV, 50000, clock cycles per digit slot (BLANK_CYC+2..2^20)
BLANK_CYC, 16, cycles at the start of each slot with all digits off (>=1, <CLK_DIV)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
value_i  in  4*DIGITS  new display value; nibble k is digit k, digit 0 rightmost
load_i  in  1  value_i valid
load_ready_o  out  1  controller can accept value_i
code_led_o  out  4  nibble to the shared decoder
digit_en_o  out  DIGITS  active-low digit enables, at most one low
blank_o  out  1  high while all digits are off
frame_o  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset (async assert, sync release) sets:
  - prescaler = 0, idx = 0, state = BLANK.
  - disp_r = 0, pend_r = 0, pend_v = 0.
  - code_led_o = 0, digit_en_o = all ones, blank_o = 1, frame_o = 0, load_ready_o = 1.
- Reset asserted mid-slot turns all digits off immediately and discards any pending value.
- Prescaler:
  - Counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and idx advances; idx wraps DIGITS-1 -> 0.
- State machine (registered outputs):
  - BLANK: prescaler 0..BLANK_CYC-1. digit_en_o = all ones, blank_o = 1, code_led_o = disp_r[4*idx+:4].
    - The nibble is presented from the first BLANK cycle, so the decoder's one-cycle latency is absorbed by the gap.
  - SHOW: prescaler BLANK_CYC..CLK_DIV-1. digit_en_o bit idx = 0, all other bits = 1, blank_o = 0, code_led_o unchanged.
  - BLANK -> SHOW when prescaler == BLANK_CYC-1.
  - SHOW -> BLANK when prescaler == CLK_DIV-1.
  - Output timing: the registered outputs change on the clock edge after these conditions.
- Frame boundary is the cycle where prescaler == CLK_DIV-1 and idx == DIGITS-1.
  - frame_o is high for exactly that cycle.
- Handshake:
  - load_ready_o = ~pend_v.
  - Transfer occurs when load_i && load_ready_o: pend_r <= value_i, pend_v <= 1.
  - load_i while load_ready_o = 0 is ignored; the source must hold the value.
- Commit:
  - On a frame boundary with pend_v = 1: disp_r <= pend_r and pend_v <= 0. load_ready_o rises on the next cycle.
  - A transfer on a frame-boundary cycle with pend_v = 0 is stored in pend_r and commits at the next frame boundary, never in the same cycle.
- The display value changes only when idx returns to 0, so all digits of one frame come from the same value.
- Frame period = DIGITS*CLK_DIV cycles, exact, with no drift.

Optional Feature:
SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - During SHOW, digit idx stays off when idx != 0 and nibbles idx..DIGITS-1 of disp_r are all zero. blank_o = 1 in that case.
  - Digit 0 always lights, so value 0 shows a single "0".
  - Slot timing is unchanged.
- Undefined: every digit lights in its slot, including leading zeros.

Test Plan:
Parameters for all scenarios: DIGITS=4, CLK_DIV=8, BLANK_CYC=2.
- Reset release, no load -> idx 0:
  - Cycles 0-1: digit_en_o = 4'b1111, blank_o = 1, code_led_o = 0.
  - Cycles 2-7: digit_en_o = 4'b1110.
  - Cycle 8: idx 1 blank; digit_en_o = 4'b1101 at cycles 10-15.
  - frame_o pulses at cycles 31, 63.
- Load 16'h1A3F at cycle 5 -> load_ready_o = 0 from cycle 6.
  - Commit at cycle 31; load_ready_o = 1 at cycle 32.
  - code_led_o over the next frame = F, 3, A, 1; decoder segments = ~7'h47, ~7'h79, ~7'h77, ~7'h30 one cycle later.
- Second load while pending -> ignored; the displayed frame shows the first value and load_ready_o stays low until the boundary.
- Load asserted exactly on frame-boundary cycle 31 with pend_v = 0 -> not displayed in frame 32-63; displayed from cycle 64.
- Assert rst_n_i at cycle 12 (digit 1 lit) -> digit_en_o = 4'b1111 in the same cycle, pending cleared. After release the scan restarts at idx 0 with disp_r = 0.
- With SEG_SCAN_LZB_EN, value 16'h0050 -> digits 3, 2 off in all SHOW cycles; digit 1 lights "5", digit 0 lights "0".
  - Without the macro, all four digits light.
